uart_tx_slave: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the RV32 core's Avalon-style data port (the MEM-stage bus signals `av_address`, `av_writedata`, `av_write_n`, `av_read_n`, `av_readdata`, `av_waitrequest`). Store bytes written to the data/status address are queued in a small FIFO and serialised as 8N1 frames on `tx`. When the FIFO is full, the block back-pressures the core through `av_waitrequest`. Loads from the same address return transmitter status.

---
 rtl/uart_tx_slave.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_slave.sv | 594 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_slave.sv
// uart_tx_slave: memory-mapped 8N1 UART transmitter with a byte FIFO
// on the core data port; loads from the same address return status.
module uart_tx_slave #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h108
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] av_address,
   input  logic [31:0] av_writedata,
   input  logic        av_write_n,
   input  logic        av_read_n,
   output logic [31:0] av_readdata,
   output logic        av_waitrequest,
   output logic        tx,
   output logic        tx_busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic hit;
   logic wr_req;
   logic rd_req;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic        tx_q, tx_d;
   logic        baud_done;

   logic [31:0] status;
   logic        unused_wdata;

   assign unused_wdata = ^av_writedata[31:8];

   assign hit        = (av_address == BASE_ADDR);
   assign wr_req     = hit & ~av_write_n;
   assign rd_req     = hit & ~av_read_n;
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign push       = wr_req & ~fifo_full;

   assign av_waitrequest = wr_req & fifo_full;

   assign tx_busy = (state_q != S_IDLE) | ~fifo_empty;
   assign tx      = tx_q;

   assign status = {16'h0, 8'(count), 5'h0,
                    fifo_empty, fifo_full, tx_busy};
   assign av_readdata = rd_req ? status : 32'h0;

   assign baud_done = (baud_q == 16'h0);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr];
               bit_d   = 3'd0;
               baud_d  = BAUD_RELOAD;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_done) begin
               baud_d  = BAUD_RELOAD;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_done) begin
               // chain straight into the next frame, no idle gap
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr];
                  bit_d   = 3'd0;
                  baud_d  = BAUD_RELOAD;
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= av_writedata[7:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= 16'h0;
         shift_q <= 8'h0;
         bit_q   <= 3'd0;
         tx_q    <= 1'b1;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: randomized scenario bench with a serial-line
// frame decoder acting as the reference receiver.
module tb_uart_tx_slave;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
   localparam int FRAME   = 10 * CLK_DIV;
   localparam logic [31:0] BASE = 32'h108;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] av_address = 32'h0;
   logic [31:0] av_writedata = 32'h0;
   logic        av_write_n = 1'b1;
   logic        av_read_n = 1'b1;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic        tx;
   logic        tx_busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         start_q[$];
   int         frame_err = 0;
   logic       mon_active = 1'b0;
   int         mon_pos = 0;
   logic       mon_s[FRAME];

   int last_acc;
   int last_stall;

   uart_tx_slave #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .av_address    (av_address),
      .av_writedata  (av_writedata),
      .av_write_n    (av_write_n),
      .av_read_n     (av_read_n),
      .av_readdata   (av_readdata),
      .av_waitrequest(av_waitrequest),
      .tx            (tx),
      .tx_busy       (tx_busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // serial receiver: one sample per cycle, each bit must hold CLK_DIV cycles
   always @(negedge clock) begin : mon
      logic [9:0] bits;
      if (reset) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_s[0]   = 1'b0;
            mon_pos    = 1;
            start_q.push_back(cyc);
         end
      end else begin
         mon_s[mon_pos] = tx;
         mon_pos++;
         if (mon_pos == FRAME) begin
            for (int k = 0; k < 10; k++) begin
               bits[k] = mon_s[k*CLK_DIV];
               for (int j = 1; j < CLK_DIV; j++)
                  if (mon_s[k*CLK_DIV+j] !== bits[k]) frame_err++;
            end
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
            rx_q.push_back(bits[8:1]);
            mon_active = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // all tasks start and end at posedge + 1
   task automatic do_reset();
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      rx_q.delete();
      start_q.delete();
      frame_err = 0;
      @(posedge clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      av_address   = BASE;
      av_writedata = {24'($urandom), b};
      av_write_n   = 1'b0;
      last_stall   = 0;
      forever begin
         @(negedge clock);
         if (!av_waitrequest) break;
         last_stall++;
         if (last_stall > 4 * FRAME) begin
            tests++;
            fails++;
            $display("FAIL write_timeout: stalled %0d cycles, limit %0d",
                     last_stall, 4 * FRAME);
            break;
         end
      end
      last_acc = cyc + 1;
      @(posedge clock);
      #1;
      av_write_n = 1'b1;
      av_address = 32'h0;
   endtask

   task automatic read_status(input logic [31:0] addr,
                              output logic [31:0] data,
                              output logic wr);
      av_address = addr;
      av_read_n  = 1'b0;
      @(negedge clock);
      data = av_readdata;
      wr   = av_waitrequest;
      @(posedge clock);
      #1;
      av_read_n  = 1'b1;
      av_address = 32'h0;
   endtask

   task automatic wait_frames(input int n);
      int budget;
      budget = (n + 1) * FRAME + 20;
      while (rx_q.size() < n && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        wr;
      #1 reset = 1'b1;
      #1;
      tests++;
      if (tx !== 1'b1) begin
         fails++;
         $display("FAIL reset_tx: got %b want 1", tx);
      end
      tests++;
      if (tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b want 0", tx_busy);
      end
      do_reset();
      read_status(BASE, rd, wr);
      tests++;
      if (rd !== 32'h4) begin
         fails++;
         $display("FAIL reset_status: got %h want %h", rd, 32'h4);
      end
      tests++;
      if (wr !== 1'b0) begin
         fails++;
         $display("FAIL reset_wait: got %b want 0", wr);
      end
      read_status(32'h10C, rd, wr);
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL reset_miss_read: got %h want 0", rd);
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      logic [9:0] fr;
      logic       exp_tx;
      logic       exp_busy;
      int         acc;
      do_reset();
      b  = 8'hA5;
      fr = {1'b1, b, 1'b0};
      write_byte(b);
      acc = last_acc;
      for (int i = 0; i <= FRAME + 1; i++) begin
         @(negedge clock);
         exp_tx   = (i == 0 || i > FRAME) ? 1'b1 : fr[(i-1)/CLK_DIV];
         exp_busy = (i <= FRAME);
         tests++;
         if (tx !== exp_tx) begin
            fails++;
            $display("FAIL single_tx[%0d]: got %b want %b", i, tx, exp_tx);
         end
         tests++;
         if (tx_busy !== exp_busy) begin
            fails++;
            $display("FAIL single_busy[%0d]: got %b want %b",
                     i, tx_busy, exp_busy);
         end
      end
      @(posedge clock);
      #1;
      tests++;
      if (rx_q.size() !== 1 || start_q.size() !== 1) begin
         fails++;
         $display("FAIL single_count: got %0d want 1", rx_q.size());
      end else begin
         tests++;
         if (rx_q[0] !== b) begin
            fails++;
            $display("FAIL single_data: got %h want %h", rx_q[0], b);
         end
         tests++;
         if (start_q[0] !== acc + 1) begin
            fails++;
            $display("FAIL single_latency: got %0d want %0d",
                     start_q[0], acc + 1);
         end
      end
   endtask

   task automatic test_status();
      logic [7:0]  b[3];
      logic [31:0] rd;
      logic [31:0] exp;
      logic        wr;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         b[i] = 8'($urandom);
         write_byte(b[i]);
      end
      // three pushed, one already taken by the transmitter
      exp = {16'h0, 8'(3 - 1), 5'h0, 1'b0, 1'b0, 1'b1};
      read_status(BASE, rd, wr);
      tests++;
      if (rd !== exp) begin
         fails++;
         $display("FAIL status_busy: got %h want %h", rd, exp);
      end
      read_status(32'h104, rd, wr);
      tests++;
      if (rd !== 32'h0) begin
         fails++;
         $display("FAIL status_miss: got %h want 0", rd);
      end
      wait_frames(3);
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= rx_q.size() || rx_q[i] !== b[i]) begin
            fails++;
            $display("FAIL status_data[%0d]: got %h want %h", i,
                     (i < rx_q.size()) ? rx_q[i] : 8'hxx, b[i]);
         end
      end
      read_status(BASE, rd, wr);
      tests++;
      if (rd !== 32'h4) begin
         fails++;
         $display("FAIL status_drained: got %h want %h", rd, 32'h4);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] b[6];
      int         acc[6];
      int         stall[6];
      int         exp_acc;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         b[i] = 8'($urandom);
         write_byte(b[i]);
         acc[i]   = last_acc;
         stall[i] = last_stall;
      end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (stall[i] !== 0) begin
            fails++;
            $display("FAIL bp_nostall[%0d]: got %0d want 0", i, stall[i]);
         end
      end
      // slot frees at start of frame 2; write lands one edge later
      exp_acc = acc[0] + 1 + FRAME + 1;
      tests++;
      if (acc[5] !== exp_acc) begin
         fails++;
         $display("FAIL bp_accept: got %0d want %0d", acc[5], exp_acc);
      end
      tests++;
      if (stall[5] !== exp_acc - acc[4] - 1) begin
         fails++;
         $display("FAIL bp_stall: got %0d want %0d",
                  stall[5], exp_acc - acc[4] - 1);
      end
      wait_frames(6);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (i >= rx_q.size() || rx_q[i] !== b[i]) begin
            fails++;
            $display("FAIL bp_data[%0d]: got %h want %h", i,
                     (i < rx_q.size()) ? rx_q[i] : 8'hxx, b[i]);
         end
      end
      for (int i = 1; i < 6; i++) begin
         tests++;
         if (i >= start_q.size() || start_q[i] - start_q[i-1] !== FRAME) begin
            fails++;
            $display("FAIL bp_gap[%0d]: got %0d want %0d", i,
                     (i < start_q.size()) ? start_q[i] - start_q[i-1] : -1,
                     FRAME);
         end
      end
      tests++;
      if (frame_err !== 0) begin
         fails++;
         $display("FAIL bp_framing: got %0d errors want 0", frame_err);
      end
   endtask

   task automatic test_both_strobes();
      logic [7:0]  b[5];
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         b[i] = 8'($urandom);
         write_byte(b[i]);
      end
      av_address   = BASE;
      av_writedata = $urandom;
      av_write_n   = 1'b0;
      av_read_n    = 1'b0;
      @(negedge clock);
      exp = {16'h0, 8'(DEPTH), 5'h0, 1'b0, 1'b1, 1'b1};
      tests++;
      if (av_waitrequest !== 1'b1) begin
         fails++;
         $display("FAIL both_wait: got %b want 1", av_waitrequest);
      end
      tests++;
      if (av_readdata !== exp) begin
         fails++;
         $display("FAIL both_status: got %h want %h", av_readdata, exp);
      end
      @(posedge clock);
      #1;
      av_address = 32'h104;
      @(negedge clock);
      tests++;
      if (av_waitrequest !== 1'b0 || av_readdata !== 32'h0) begin
         fails++;
         $display("FAIL full_miss: got wait=%b rd=%h want wait=0 rd=0",
                  av_waitrequest, av_readdata);
      end
      @(posedge clock);
      #1;
      av_write_n = 1'b1;
      av_read_n  = 1'b1;
      av_address = 32'h0;
      wait_frames(5);
      repeat (2 * FRAME) @(posedge clock);
      #1;
      tests++;
      if (rx_q.size() !== 5) begin
         fails++;
         $display("FAIL both_count: got %0d want 5", rx_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (rx_q[i] !== b[i]) begin
               fails++;
               $display("FAIL both_data[%0d]: got %h want %h",
                        i, rx_q[i], b[i]);
            end
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] addrs[2];
      logic [31:0] rd;
      logic        wr;
      int          bad;
      addrs[0] = 32'h104;
      addrs[1] = 32'h10C;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         av_address   = addrs[i];
         av_writedata = $urandom;
         av_write_n   = 1'b0;
         av_read_n    = 1'b0;
         @(negedge clock);
         tests++;
         if (av_waitrequest !== 1'b0 || av_readdata !== 32'h0) begin
            fails++;
            $display("FAIL decode_wr[%h]: got wait=%b rd=%h want 0/0",
                     addrs[i], av_waitrequest, av_readdata);
         end
         @(posedge clock);
         #1;
         av_write_n = 1'b1;
         read_status(addrs[i], rd, wr);
         tests++;
         if (rd !== 32'h0) begin
            fails++;
            $display("FAIL decode_rd[%h]: got %h want 0", addrs[i], rd);
         end
      end
      read_status(BASE, rd, wr);
      tests++;
      if (rd !== 32'h4) begin
         fails++;
         $display("FAIL decode_status: got %h want %h", rd, 32'h4);
      end
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clock);
         if (tx !== 1'b1) bad++;
      end
      @(posedge clock);
      #1;
      tests++;
      if (bad !== 0 || rx_q.size() !== 0) begin
         fails++;
         $display("FAIL decode_line: got %0d low cycles %0d frames want 0",
                  bad, rx_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        wr;
      int          acc;
      int          budget;
      do_reset();
      write_byte(8'($urandom));
      acc = last_acc;
      write_byte(8'($urandom));
      write_byte(8'($urandom));
      // frame starts acc+1; data bit 3 is frame bit 4
      budget = 4 * FRAME;
      while (cyc < acc + 1 + 4 * CLK_DIV + 1 && budget > 0) begin
         @(negedge clock);
         budget--;
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (tx !== 1'b1) begin
         fails++;
         $display("FAIL midreset_tx: got %b want 1", tx);
      end
      tests++;
      if (tx_busy !== 1'b0) begin
         fails++;
         $display("FAIL midreset_busy: got %b want 0", tx_busy);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      rx_q.delete();
      start_q.delete();
      frame_err = 0;
      @(posedge clock);
      #1;
      read_status(BASE, rd, wr);
      tests++;
      if (rd !== 32'h4) begin
         fails++;
         $display("FAIL midreset_status: got %h want %h", rd, 32'h4);
      end
      write_byte(8'h3C);
      wait_frames(1);
      repeat (3 * FRAME) @(posedge clock);
      #1;
      tests++;
      if (rx_q.size() !== 1 || frame_err !== 0) begin
         fails++;
         $display("FAIL midreset_frames: got %0d frames %0d errs want 1 0",
                  rx_q.size(), frame_err);
      end else begin
         tests++;
         if (rx_q[0] !== 8'h3C) begin
            fails++;
            $display("FAIL midreset_data: got %h want 3c", rx_q[0]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] base;
      logic [7:0] exp[$];
      int         n;
      do_reset();
      base = 8'($urandom);
      n    = 2 * DEPTH + 1;
      for (int i = 0; i < n; i++) begin
         exp.push_back(base + 8'(i));
         write_byte(base + 8'(i));
      end
      wait_frames(n);
      tests++;
      if (rx_q.size() !== n) begin
         fails++;
         $display("FAIL wrap_count: got %0d want %0d", rx_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            tests++;
            if (rx_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL wrap_data[%0d]: got %h want %h",
                        i, rx_q[i], exp[i]);
            end
         end
         for (int i = 1; i < n; i++) begin
            tests++;
            if (start_q[i] - start_q[i-1] !== FRAME) begin
               fails++;
               $display("FAIL wrap_gap[%0d]: got %0d want %0d",
                        i, start_q[i] - start_q[i-1], FRAME);
            end
         end
      end
      tests++;
      if (frame_err !== 0) begin
         fails++;
         $display("FAIL wrap_framing: got %0d want 0", frame_err);
      end
   endtask

   task automatic test_random_stream();
      logic [7:0] exp[$];
      logic [7:0] b;
      int         gap;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         gap = $urandom_range(FRAME + 10, 0);
         repeat (gap) @(posedge clock);
         #1;
         b = 8'($urandom);
         exp.push_back(b);
         write_byte(b);
      end
      wait_frames(12);
      tests++;
      if (rx_q.size() !== exp.size()) begin
         fails++;
         $display("FAIL rand_count: got %0d want %0d",
                  rx_q.size(), exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL rand_data[%0d]: got %h want %h",
                        i, rx_q[i], exp[i]);
            end
         end
      end
      tests++;
      if (frame_err !== 0) begin
         fails++;
         $display("FAIL rand_framing: got %0d want 0", frame_err);
      end
   endtask

   initial begin
      @(posedge clock);
      test_reset();
      test_single_byte();
      test_status();
      test_backpressure();
      test_both_strobes();
      test_decode();
      test_reset_mid();
      test_wrap();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
